// File: rtl/weight_drm_loader_pkg.sv
// Shared constants, state encodings and bundles for the weight DRM loader.
// Imported by the line packer and the loader top.
package weight_drm_loader_pkg;

    // Width of one DRM write word (one packed weight word).
    localparam int WEIGHT_WORD_WIDTH = 36;
    // Number of DRMs fed in parallel, i.e. words per packed line.
    localparam int WEIGHT_DRM_NUM    = 9;
    // Weight DRM write address width.
    localparam int WEIGHT_ADDR_WIDTH = 10;

    // Loader FSM encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // One DRM line write as seen on the write port.
    typedef struct packed {
        logic [WEIGHT_ADDR_WIDTH-1:0]                  addr;
        logic [WEIGHT_WORD_WIDTH*WEIGHT_DRM_NUM-1:0]   data;
    } drm_wr_t;

    // Address of line n of a load, wrapping modulo the DRM depth.
    function automatic logic [WEIGHT_ADDR_WIDTH-1:0] line_addr(
        input logic [WEIGHT_ADDR_WIDTH-1:0] base,
        input logic [WEIGHT_ADDR_WIDTH-1:0] line_idx
    );
        return base + line_idx;
    endfunction

endpackage

// File: rtl/weight_drm_loader_packer.sv
// weight_line_packer: assembles WORD_WIDTH words into a DRM_NUM-word line.
// Ports: clk, rstn, word_accept/word_data in; line_data, line_complete out.
module weight_line_packer
    import weight_drm_loader_pkg::*;
#(
    parameter int WORD_WIDTH = WEIGHT_WORD_WIDTH,
    parameter int DRM_NUM    = WEIGHT_DRM_NUM
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          word_accept,
    input  logic [WORD_WIDTH-1:0]         word_data,
    output logic [WORD_WIDTH*DRM_NUM-1:0] line_data,
    output logic                          line_complete
);

    localparam int LINE_W = WORD_WIDTH * DRM_NUM;
    localparam int CNT_W  = (DRM_NUM > 1) ? $clog2(DRM_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DRM_NUM - 1);

    logic [CNT_W-1:0]  word_cnt;
    logic [LINE_W-1:0] line_q;

    // The line including the word currently offered. On the last word this
    // is the finished line, handed to the output stage in the same cycle so
    // the next line can start packing without a bubble.
    always_comb begin
        line_data = line_q;
        line_data[word_cnt*WORD_WIDTH +: WORD_WIDTH] = word_data;
    end

    assign line_complete = word_accept && (word_cnt == LAST_WORD);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_cnt <= '0;
            line_q   <= '0;
        end else if (word_accept) begin
            line_q <= line_data;
            if (word_cnt == LAST_WORD) begin
                word_cnt <= '0;
            end else begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_drm_loader.sv
// Packs a stream of weight words into lines and writes them to the DRM.
// Ports: load_* control, weight_in_* stream, WeightDRM_*_wr write port.
module weight_drm_loader
    import weight_drm_loader_pkg::*;
#(
    parameter int WORD_WIDTH     = WEIGHT_WORD_WIDTH,
    parameter int DRM_NUM        = WEIGHT_DRM_NUM,
    parameter int DATA_OUT_WIDTH = WEIGHT_WORD_WIDTH * WEIGHT_DRM_NUM,
    parameter int WR_ADDR_DEPTH  = WEIGHT_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      load_start,
    input  logic [WR_ADDR_DEPTH-1:0]  load_base_addr,
    input  logic [WR_ADDR_DEPTH:0]    load_num_lines,
    output logic                      load_busy,
    output logic                      load_done,
    input  logic [WORD_WIDTH-1:0]     weight_in_data,
    input  logic                      weight_in_valid,
    output logic                      weight_in_ready,
    output logic [DATA_OUT_WIDTH-1:0] WeightDRM_data_wr,
    output logic                      WeightDRM_valid_wr,
    output logic [WR_ADDR_DEPTH-1:0]  WeightDRM_addr_wr
);

    logic [1:0]                state_q;
    logic [1:0]                state_d;
    logic [WR_ADDR_DEPTH-1:0]  base_q;
    logic [WR_ADDR_DEPTH:0]    num_lines_q;
    logic [WR_ADDR_DEPTH:0]    line_cnt_q;
    logic                      start_ok;
    logic                      accept;
    logic                      line_complete;
    logic                      last_line;
    logic [DATA_OUT_WIDTH-1:0] line_data;

    assign start_ok = (state_q == ST_IDLE) && load_start;

    // line_cnt counts completed lines, so this also bounds the total word
    // count at num_lines*DRM_NUM.
    assign weight_in_ready = (state_q == ST_LOAD)
                          && (line_cnt_q < num_lines_q);

    assign accept    = weight_in_valid && weight_in_ready;
    assign last_line = (line_cnt_q == num_lines_q - 1'b1);

    assign load_busy = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign load_done = (state_q == ST_DONE);

    weight_line_packer #(
        .WORD_WIDTH (WORD_WIDTH),
        .DRM_NUM    (DRM_NUM)
    ) u_packer (
        .clk           (clk),
        .rstn          (rstn),
        .word_accept   (accept),
        .word_data     (weight_in_data),
        .line_data     (line_data),
        .line_complete (line_complete)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = (load_num_lines == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (line_complete && last_line) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            num_lines_q <= '0;
            line_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                base_q      <= load_base_addr;
                num_lines_q <= load_num_lines;
                line_cnt_q  <= '0;
            end else if (line_complete) begin
                line_cnt_q <= line_cnt_q + 1'b1;
            end
        end
    end

    // Output stage: one registered write per completed line. Data and
    // address hold between writes.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            WeightDRM_valid_wr <= 1'b0;
            WeightDRM_data_wr  <= '0;
            WeightDRM_addr_wr  <= '0;
        end else begin
            WeightDRM_valid_wr <= line_complete;
            if (line_complete) begin
                WeightDRM_data_wr <= line_data;
                WeightDRM_addr_wr <= base_q
                                   + line_cnt_q[WR_ADDR_DEPTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_weight_drm_loader.sv
// Directed scoreboard bench for weight_drm_loader.
// Expected line writes are queued as words are driven and popped on writes.
module tb_weight_drm_loader;
    import weight_drm_loader_pkg::*;

    logic         clk;
    logic         rstn;
    logic         load_start;
    logic [9:0]   load_base_addr;
    logic [10:0]  load_num_lines;
    logic         load_busy;
    logic         load_done;
    logic [35:0]  weight_in_data;
    logic         weight_in_valid;
    logic         weight_in_ready;
    logic [323:0] WeightDRM_data_wr;
    logic         WeightDRM_valid_wr;
    logic [9:0]   WeightDRM_addr_wr;

    weight_drm_loader dut (
        .clk                (clk),
        .rstn               (rstn),
        .load_start         (load_start),
        .load_base_addr     (load_base_addr),
        .load_num_lines     (load_num_lines),
        .load_busy          (load_busy),
        .load_done          (load_done),
        .weight_in_data     (weight_in_data),
        .weight_in_valid    (weight_in_valid),
        .weight_in_ready    (weight_in_ready),
        .WeightDRM_data_wr  (WeightDRM_data_wr),
        .WeightDRM_valid_wr (WeightDRM_valid_wr),
        .WeightDRM_addr_wr  (WeightDRM_addr_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_count = 0;
    int rdy_count = 0;
    int wr_count = 0;
    int done_count = 0;
    int last_acc_cyc = 0;
    int last_wr_cyc = 0;
    int wr_gap = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    drm_wr_t exp_q[$];
    drm_wr_t got;

    task automatic check(input string tag, input logic [323:0] obs,
                         input logic [323:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (weight_in_ready) rdy_count++;
            if (weight_in_valid && weight_in_ready) begin
                acc_count++;
                last_acc_cyc = cyc;
            end
            if (WeightDRM_valid_wr) begin
                if (wr_count > 0) wr_gap = cyc - last_wr_cyc;
                last_wr_cyc = cyc;
                wr_count++;
                check("wr_expected", 324'(exp_q.size() != 0), 324'(1));
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    check("wr_addr", 324'(WeightDRM_addr_wr), 324'(got.addr));
                    check("wr_data", WeightDRM_data_wr, got.data);
                end
            end
            if (load_done) begin
                done_count++;
                done_cyc = cyc;
                check("busy_at_done", 324'(load_busy), 324'(0));
            end
        end
    end

    task automatic send_word(input logic [35:0] w, input int gap);
        int n;
        bit ok;
        for (int g = 0; g < gap; g++) begin
            weight_in_valid = 1'b0;
            @(posedge clk); #1;
        end
        weight_in_valid = 1'b1;
        weight_in_data  = w;
        n  = 0;
        ok = 0;
        while (!ok) begin
            @(negedge clk);
            if (weight_in_ready) ok = 1;
            @(posedge clk); #1;
            n++;
            if (!ok && n > 20) begin
                check("accept_timeout", 324'(weight_in_ready), 324'(1));
                ok = 1;
            end
        end
        weight_in_valid = 1'b0;
    endtask

    task automatic run_load(input logic [9:0] base, input int lines,
                            input logic [35:0] first, input bit gaps,
                            input bit mid_start, input bit hold_after);
        logic [323:0] line;
        logic [35:0]  w;
        logic [9:0]   a;
        int w0, a0, d0, r0, n;
        line = '0;
        w0 = wr_count;
        a0 = acc_count;
        d0 = done_count;
        r0 = rdy_count;
        @(posedge clk); #1;
        load_base_addr = base;
        load_num_lines = 11'(lines);
        load_start     = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        load_start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 324'(load_busy), 324'(lines != 0));
        check("ready_after_start", 324'(weight_in_ready), 324'(lines != 0));
        @(posedge clk); #1;
        for (int l = 0; l < lines; l++) begin
            for (int k = 0; k < 9; k++) begin
                w = first + 36'(l * 9 + k);
                line[k*36 +: 36] = w;
                if (k == 8) begin
                    a = base + 10'(l);
                    exp_q.push_back('{addr: a, data: line});
                end
                if (mid_start && l == 0 && k == 5) begin
                    load_start     = 1'b1;
                    load_base_addr = 10'd500;
                    load_num_lines = 11'd1;
                end
                send_word(w, gaps ? int'($urandom_range(0, 3)) : 0);
                load_start = 1'b0;
            end
        end
        if (hold_after) begin
            weight_in_valid = 1'b1;
            weight_in_data  = '1;
        end
        n = 0;
        while (done_count == d0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        weight_in_valid = 1'b0;
        check("done_pulses", 324'(done_count - d0), 324'(1));
        if (lines == 0) begin
            check("done_after_start", 324'(done_cyc - start_cyc), 324'(1));
            check("ready_never", 324'(rdy_count - r0), 324'(0));
        end else begin
            check("done_after_last", 324'(done_cyc - last_acc_cyc), 324'(2));
        end
        check("accept_count", 324'(acc_count - a0), 324'(lines * 9));
        check("write_count", 324'(wr_count - w0), 324'(lines));
        check("queue_drained", 324'(exp_q.size()), 324'(0));
        if (!gaps && lines > 1) begin
            check("wr_spacing", 324'(wr_gap), 324'(9));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  324'(load_busy),          324'(0));
        check({tag, "_done"},  324'(load_done),          324'(0));
        check({tag, "_ready"}, 324'(weight_in_ready),    324'(0));
        check({tag, "_valid"}, 324'(WeightDRM_valid_wr), 324'(0));
        check({tag, "_data"},  WeightDRM_data_wr,        324'(0));
        check({tag, "_addr"},  324'(WeightDRM_addr_wr),  324'(0));
    endtask

    initial begin
        int w0;
        rstn            = 1'b0;
        load_start      = 1'b0;
        load_base_addr  = '0;
        load_num_lines  = '0;
        weight_in_data  = '0;
        weight_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Gap-free two-line load, extra valid words offered afterwards.
        run_load(10'd0, 2, 36'h1, 1'b0, 1'b0, 1'b1);
        // Address wrap past the top of the DRM.
        run_load(10'd1022, 4, 36'h100, 1'b0, 1'b0, 1'b0);
        // Zero-line load.
        run_load(10'd7, 0, 36'h0, 1'b0, 1'b0, 1'b0);
        // Random gaps and an ignored mid-load start, same data as first run.
        run_load(10'd0, 2, 36'h1, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of a line.
        w0 = wr_count;
        @(posedge clk); #1;
        load_base_addr = 10'd0;
        load_num_lines = 11'd2;
        load_start     = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) send_word(36'h900 + 36'(i), 0);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_write_on_reset", 324'(wr_count - w0), 324'(0));
        run_load(10'd0, 2, 36'h700, 1'b0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        check("final_queue", 324'(exp_q.size()), 324'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
